adc_offset_scale: RTL and testbench
===================================

ADC_OFFSET_SCALE -- requirements
Module: adc_offset_scale

Interface
REQ-001 SHALL have parameter CAL_LOG2, default 4; calibration averages 2^CAL_LOG2 samples.
REQ-002 SHALL have parameter GAIN, default 16384; signed 16-bit gain, Q2.14.
REQ-003 SHALL have parameter SHIFT, default 14; arithmetic right shift applied after multiply.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port sample_in, input, 12, unsigned ADC code from the serial ADC front end.
REQ-007 SHALL have port sample_valid, input, 1, one-cycle strobe qualifying sample_in.
REQ-008 SHALL have port trip_limit, input, 16, unsigned overcurrent magnitude threshold.
REQ-009 SHALL have port recal, input, 1, pulse requesting re-calibration.
REQ-010 SHALL have port fault_clr, input, 1, pulse clearing a latched fault.
REQ-011 SHALL have port value_out, output, 16, signed scaled, offset-corrected sample.
REQ-012 SHALL have port value_valid, output, 1, one-cycle strobe qualifying value_out.
REQ-013 SHALL have port offset_out, output, 12, current calibrated zero offset.
REQ-014 SHALL have port calib_done, output, 1, high while in RUN or FAULT.
REQ-015 SHALL have port fault, output, 1, latched overcurrent flag.

Function
REQ-016 SHALL implement three states: CALIB, RUN, FAULT; reset enters CALIB.
REQ-017 CALIB: each sample_valid adds sample_in to a (12+CAL_LOG2)-bit accumulator and increments a sample counter.
REQ-018 On the 2^CAL_LOG2-th calibration sample, offset_out SHALL register acc>>CAL_LOG2 (truncating), accumulator/counter clear, state -> RUN, calib_done high at the same edge.
REQ-019 A sample_valid arriving in the first RUN cycle SHALL use the new offset.
REQ-020 No value_valid SHALL be produced in CALIB.
REQ-021 RUN pipeline stage 1: diff = sample_in - offset_out, 13-bit signed.
REQ-022 Stage 2: product = diff * GAIN, 29-bit signed, full precision.
REQ-023 Stage 3: product arithmetic-shifted right by SHIFT, saturated to [-32768, 32767], registered onto value_out.
REQ-024 value_valid SHALL pulse exactly 3 cycles after the accepting sample_valid; throughput one sample per cycle.
REQ-025 Trip: at stage 3, if |saturated result| > trip_limit (17-bit magnitude, |-32768| = 32768) then fault sets and state -> FAULT.
REQ-026 The tripping sample SHALL still be output with value_valid=1 in the same cycle fault rises.
REQ-027 FAULT: value_out forced 0, value_valid 0, pipeline valid bits flushed, sample_valid ignored.
REQ-028 fault_clr in FAULT SHALL return to RUN next edge, fault 0, offset retained; fault_clr elsewhere ignored.
REQ-029 recal in RUN SHALL flush the pipeline, drop calib_done, enter CALIB with cleared accumulator; recal in FAULT ignored.
REQ-030 Simultaneous trip and recal in RUN: trip wins (FAULT).
REQ-031 value_out SHALL hold its last value between value_valid pulses.

Reset
REQ-032 rst SHALL clear value_out, value_valid, offset_out, calib_done, fault, accumulator, counter and pipeline valids, and force CALIB.
REQ-033 rst asserted mid-operation SHALL discard in-flight samples; no value_valid until after a full recalibration.

Structure
REQ-034 A shared package adc_pkg SHALL hold ADC_W=12, OUT_W=16 and the state encoding (CALIB, RUN, FAULT).
REQ-035 Shift-and-saturate SHALL be a sub-module sat_shift (29-bit signed in, SHIFT parameter, 16-bit saturated out).

Verification
REQ-036 16 samples of 2048 after reset -> offset_out=2048, calib_done rises on the edge of the 16th sample, no value_valid.
REQ-037 Defaults, offset 2048, sample 3000, trip_limit 1500 -> value_out=952 valid 3 cycles later, fault stays 0.
REQ-038 Offset 2048, sample 4000, trip_limit 1500 -> value_out=1952 with value_valid and fault high; later samples yield no value_valid; fault_clr -> RUN, next sample 3000 gives 952.
REQ-039 GAIN=32767, SHIFT=8, offset 2048, trip_limit 32768: sample 4095 -> 32767; sample 0 -> -32768; no fault.
REQ-040 Back-to-back sample_valid for 8 cycles in RUN -> 8 consecutive value_valid pulses, order preserved; rst asserted mid-burst -> no further value_valid, calib_done 0.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg: shared widths and FSM encoding for the ADC offset/scale block.
//   ADC_W  - raw ADC code width
//   OUT_W  - scaled output width
//   DIFF_W - signed offset-corrected difference width
//   PROD_W - full-precision product width (DIFF_W + 16-bit gain)
//   CALIB/RUN/FAULT - state encoding, exposed on the top-level state_o port
package adc_pkg;

    localparam int ADC_W  = 12;
    localparam int OUT_W  = 16;
    localparam int DIFF_W = ADC_W + 1;
    localparam int PROD_W = 29;

    localparam logic [1:0] CALIB = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    // Magnitude of a signed OUT_W value in OUT_W+1 bits, so that the most
    // negative code maps to +2^(OUT_W-1) without wrapping.
    function automatic logic [OUT_W:0] mag_of(input logic [OUT_W-1:0] v);
        logic [OUT_W:0] ext;
        ext = {v[OUT_W-1], v};
        return v[OUT_W-1] ? (~ext + (OUT_W+1)'(1)) : ext;
    endfunction

endpackage

// File: rtl/sat_shift.sv
// sat_shift: arithmetic right shift of a full-precision signed product
// followed by saturation to the signed OUT_W output range.
//   prod_i - PROD_W-bit signed product
//   sat_o  - OUT_W-bit signed result, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module sat_shift
    import adc_pkg::*;
#(
    parameter int SHIFT = 14
) (
    input  logic signed [PROD_W-1:0] prod_i,
    output logic signed [OUT_W-1:0]  sat_o
);

    localparam logic signed [PROD_W-1:0] MAX_V = PROD_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] MIN_V = PROD_W'(-(2 ** (OUT_W - 1)));

    logic signed [PROD_W-1:0] sh_w;

    always_comb begin
        sh_w = prod_i >>> SHIFT;
        if (sh_w > MAX_V) begin
            sat_o = MAX_V[OUT_W-1:0];
        end else if (sh_w < MIN_V) begin
            sat_o = MIN_V[OUT_W-1:0];
        end else begin
            sat_o = sh_w[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/adc_offset_scale.sv
// adc_offset_scale: zero-offset calibration, offset removal, gain scaling and
// overcurrent trip for a 12-bit ADC sample stream.
//
// Handshake: sample_valid and value_valid are one-cycle strobes with no
// backpressure; a sample is accepted on any rising edge where sample_valid is
// high and the block is in CALIB (accumulated) or RUN (pipelined). Each RUN
// sample appears on value_out with value_valid exactly 3 cycles later.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   sample_in     - unsigned ADC code, qualified by sample_valid
//   trip_limit    - unsigned overcurrent magnitude threshold
//   recal         - pulse: restart calibration (RUN only)
//   fault_clr     - pulse: leave FAULT back to RUN (FAULT only)
//   value_out     - signed scaled result, qualified by value_valid, held between strobes
//   offset_out    - calibrated zero offset
//   calib_done    - high in RUN or FAULT
//   fault         - latched overcurrent flag
//   state_o       - current FSM state (CALIB/RUN/FAULT encoding from adc_pkg)
module adc_offset_scale
    import adc_pkg::*;
#(
    parameter int                 CAL_LOG2 = 4,
    parameter logic signed [15:0] GAIN     = 16'sd16384,
    parameter int                 SHIFT    = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] sample_in,
    input  logic             sample_valid,
    input  logic [15:0]      trip_limit,
    input  logic             recal,
    input  logic             fault_clr,
    output logic [OUT_W-1:0] value_out,
    output logic             value_valid,
    output logic [ADC_W-1:0] offset_out,
    output logic             calib_done,
    output logic             fault,
    output logic [1:0]       state_o
);

    localparam int ACC_W = ADC_W + CAL_LOG2;

    logic [1:0]               state_q,  state_d;
    logic [ACC_W-1:0]         acc_q,    acc_d;
    logic [CAL_LOG2-1:0]      cnt_q,    cnt_d;
    logic [ADC_W-1:0]         offset_q, offset_d;
    logic                     s1_v_q,   s1_v_d;
    logic signed [DIFF_W-1:0] diff_q,   diff_d;
    logic                     s2_v_q,   s2_v_d;
    logic signed [PROD_W-1:0] prod_q,   prod_d;
    logic [OUT_W-1:0]         value_q,  value_d;
    logic                     vv_q,     vv_d;
    logic                     fault_q,  fault_d;

    logic [ACC_W-1:0]         sum_w;
    logic signed [PROD_W-1:0] diff_x_w;
    logic signed [PROD_W-1:0] gain_x_w;
    logic signed [OUT_W-1:0]  sat_w;
    logic [OUT_W:0]           mag_w;
    logic                     trip_w;

    sat_shift #(.SHIFT(SHIFT)) u_sat_shift (
        .prod_i (prod_q),
        .sat_o  (sat_w)
    );

    assign sum_w    = acc_q + ACC_W'(sample_in);
    assign diff_x_w = PROD_W'(diff_q);
    assign gain_x_w = PROD_W'(GAIN);
    assign mag_w    = mag_of(sat_w);
    // Only a sample actually leaving stage 3 in RUN can trip.
    assign trip_w   = (state_q == RUN) && s2_v_q && (mag_w > {1'b0, trip_limit});

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        s1_v_d   = 1'b0;
        diff_d   = diff_q;
        s2_v_d   = 1'b0;
        prod_d   = prod_q;
        value_d  = value_q;
        vv_d     = 1'b0;
        fault_d  = fault_q;

        case (state_q)
            CALIB: begin
                if (sample_valid) begin
                    acc_d = sum_w;
                    cnt_d = cnt_q + CAL_LOG2'(1);
                    if (&cnt_q) begin
                        // Last calibration sample: the offset is visible in the
                        // very next cycle, so the first RUN sample uses it.
                        offset_d = sum_w[ACC_W-1:CAL_LOG2];
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = RUN;
                    end
                end
            end

            RUN: begin
                if (sample_valid) begin
                    s1_v_d = 1'b1;
                    diff_d = DIFF_W'(sample_in) - DIFF_W'(offset_q);
                end
                s2_v_d = s1_v_q;
                prod_d = diff_x_w * gain_x_w;
                if (s2_v_q) begin
                    value_d = sat_w;
                    vv_d    = 1'b1;
                end

                if (trip_w) begin
                    // Tripping sample is still presented; younger ones are dropped.
                    fault_d = 1'b1;
                    state_d = FAULT;
                    s1_v_d  = 1'b0;
                    s2_v_d  = 1'b0;
                end else if (recal) begin
                    state_d = CALIB;
                    acc_d   = '0;
                    cnt_d   = '0;
                    s1_v_d  = 1'b0;
                    s2_v_d  = 1'b0;
                    vv_d    = 1'b0;
                    value_d = value_q;
                end
            end

            FAULT: begin
                value_d = '0;
                if (fault_clr) begin
                    state_d = RUN;
                    fault_d = 1'b0;
                end
            end

            default: begin
                state_d = CALIB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CALIB;
            acc_q    <= '0;
            cnt_q    <= '0;
            offset_q <= '0;
            s1_v_q   <= 1'b0;
            diff_q   <= '0;
            s2_v_q   <= 1'b0;
            prod_q   <= '0;
            value_q  <= '0;
            vv_q     <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
            s1_v_q   <= s1_v_d;
            diff_q   <= diff_d;
            s2_v_q   <= s2_v_d;
            prod_q   <= prod_d;
            value_q  <= value_d;
            vv_q     <= vv_d;
            fault_q  <= fault_d;
        end
    end

    assign value_out   = value_q;
    assign value_valid = vv_q;
    assign offset_out  = offset_q;
    assign calib_done  = (state_q == RUN) || (state_q == FAULT);
    assign fault       = fault_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_adc_offset_scale.sv
// Bench for adc_offset_scale: default-parameter instance driven through
// calibration, latency, trip/clear, bursts, recalibration and mid-burst reset;
// a second instance with GAIN=32767, SHIFT=8 covers output saturation.
module tb_adc_offset_scale;

    logic        clk;
    logic        rst;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic [15:0] trip_limit;
    logic        recal;
    logic        fault_clr;
    logic [15:0] value_out;
    logic        value_valid;
    logic [11:0] offset_out;
    logic        calib_done;
    logic        fault;
    logic [1:0]  state_o;

    logic [11:0] g_sample_in;
    logic        g_sample_valid;
    logic [15:0] g_trip_limit;
    logic        g_recal;
    logic        g_fault_clr;
    logic [15:0] g_value_out;
    logic        g_value_valid;
    logic [11:0] g_offset_out;
    logic        g_calib_done;
    logic        g_fault;
    logic [1:0]  g_state_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    adc_offset_scale dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .trip_limit(trip_limit), .recal(recal), .fault_clr(fault_clr),
        .value_out(value_out), .value_valid(value_valid), .offset_out(offset_out),
        .calib_done(calib_done), .fault(fault), .state_o(state_o)
    );

    adc_offset_scale #(.CAL_LOG2(4), .GAIN(16'sd32767), .SHIFT(8)) dut_g (
        .clk(clk), .rst(rst), .sample_in(g_sample_in), .sample_valid(g_sample_valid),
        .trip_limit(g_trip_limit), .recal(g_recal), .fault_clr(g_fault_clr),
        .value_out(g_value_out), .value_valid(g_value_valid), .offset_out(g_offset_out),
        .calib_done(g_calib_done), .fault(g_fault), .state_o(g_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // reference model: offset removal, Q-format gain, shift, clamp
    function automatic int model_val(int s, int off, int gain, int sh);
        int p;
        int r;
        p = (s - off) * gain;
        r = p >>> sh;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // scoreboard: every value_valid on the default instance must match the queue head
    always @(negedge clk) begin
        if (value_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", value_valid, 0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("value_out", $signed(value_out), $signed(e));
            end
        end
    end

    // driver tasks
    task automatic cal_dut(input bit rand_vals, output int off);
        int sum;
        int v;
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            v = rand_vals ? int'($urandom_range(0, 4095)) : 2048;
            sum += v;
            sample_in    = 12'(v);
            sample_valid = 1'b1;
            tick();
            if (i == 14) chk("calib_done_before_last", calib_done, 0);
        end
        sample_valid = 1'b0;
        off = sum >> 4;
        chk("calib_done_after_last", calib_done, 1);
        chk("offset_out", offset_out, off);
    endtask

    task automatic send1(input int s);
        sample_in    = 12'(s);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic g_send_check(input int s, input int exp, input string tag);
        g_sample_in    = 12'(s);
        g_sample_valid = 1'b1;
        tick();
        g_sample_valid = 1'b0;
        tick();
        tick();
        chk({tag, "_valid"}, g_value_valid, 1);
        chk(tag, $signed(g_value_out), exp);
        chk({tag, "_fault"}, g_fault, 0);
    endtask

    initial begin
        int off;
        int v;
        rst = 1'b1; sample_in = '0; sample_valid = 1'b0; trip_limit = 16'd1500;
        recal = 1'b0; fault_clr = 1'b0;
        g_sample_in = '0; g_sample_valid = 1'b0; g_trip_limit = 16'h8000;
        g_recal = 1'b0; g_fault_clr = 1'b0;
        tick();
        tick();
        chk("rst_value_out",   value_out,   0);
        chk("rst_value_valid", value_valid, 0);
        chk("rst_offset_out",  offset_out,  0);
        chk("rst_calib_done",  calib_done,  0);
        chk("rst_fault",       fault,       0);
        chk("rst_state",       state_o,     adc_pkg::CALIB);
        rst = 1'b0;
        tick();

        // calibration with a constant 2048 input
        cal_dut(1'b0, off);
        chk("state_run", state_o, adc_pkg::RUN);

        // single sample: exact 3-cycle latency, no trip
        exp_q.push_back(16'(model_val(3000, off, 16384, 14)));
        send1(3000);
        chk("lat_c1", value_valid, 0);
        tick();
        chk("lat_c2", value_valid, 0);
        tick();
        chk("lat_c3_valid", value_valid, 1);
        chk("lat_c3_value", $signed(value_out), 952);
        chk("no_fault", fault, 0);
        tick();
        chk("valid_one_cycle", value_valid, 0);
        chk("value_held", $signed(value_out), 952);

        // overcurrent trip
        exp_q.push_back(16'(model_val(4000, off, 16384, 14)));
        send1(4000);
        tick();
        tick();
        chk("trip_valid", value_valid, 1);
        chk("trip_value", $signed(value_out), 1952);
        chk("trip_fault", fault, 1);
        send1(3000);
        send1(3000);
        recal = 1'b1;
        send1(3000);
        recal = 1'b0;
        tick();
        tick();
        chk("fault_value_zero", value_out, 0);
        chk("fault_no_valid", value_valid, 0);
        chk("fault_latched", fault, 1);
        chk("fault_state", state_o, adc_pkg::FAULT);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_fault", fault, 0);
        chk("clr_state", state_o, adc_pkg::RUN);
        chk("clr_offset_kept", offset_out, off);
        exp_q.push_back(16'(model_val(3000, off, 16384, 14)));
        send1(3000);
        tick();
        tick();
        chk("post_clr_value", $signed(value_out), 952);

        // 8-sample back-to-back burst, no trip possible
        trip_limit = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(0, 4095));
            exp_q.push_back(16'(model_val(v, off, 16384, 14)));
            sample_in    = 12'(v);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        repeat (4) tick();
        chk("burst_drained", exp_q.size(), 0);

        // recalibration with random codes, then random traffic with gaps
        recal = 1'b1;
        tick();
        recal = 1'b0;
        chk("recal_calib_done", calib_done, 0);
        chk("recal_state", state_o, adc_pkg::CALIB);
        cal_dut(1'b1, off);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                v = int'($urandom_range(0, 4095));
                exp_q.push_back(16'(model_val(v, off, 16384, 14)));
                sample_in    = 12'(v);
                sample_valid = 1'b1;
            end else begin
                sample_valid = 1'b0;
            end
            tick();
        end
        sample_valid = 1'b0;
        repeat (4) tick();
        chk("random_drained", exp_q.size(), 0);

        // reset in the middle of a burst discards in-flight samples
        for (int i = 0; i < 2; i++) begin
            sample_in    = 12'($urandom_range(0, 4095));
            sample_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample_valid = 1'b0;
        chk("midrst_calib_done", calib_done, 0);
        chk("midrst_offset", offset_out, 0);
        chk("midrst_value_out", value_out, 0);
        repeat (6) tick();
        chk("midrst_no_valid", value_valid, 0);
        chk("midrst_state", state_o, adc_pkg::CALIB);

        // saturation on the high-gain instance
        for (int i = 0; i < 16; i++) begin
            g_sample_in    = 12'd2048;
            g_sample_valid = 1'b1;
            tick();
        end
        g_sample_valid = 1'b0;
        chk("g_offset", g_offset_out, 2048);
        g_send_check(4095, model_val(4095, 2048, 32767, 8), "g_sat_pos");
        g_send_check(0, model_val(0, 2048, 32767, 8), "g_sat_neg");
        chk("g_sat_pos_literal", model_val(4095, 2048, 32767, 8), 32767);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
